// File: rtl/at86rf215_pkg.sv
// Shared definitions for the AT86RF215 LVDS baseband IQ interface.
// The transmit serializer and the DDR capture path both import this package.
package at86rf215_pkg;

  localparam int IQ_DATA_W      = 13;
  localparam int IQ_WORD_W      = 32;
  localparam logic [1:0] SYNC_I = 2'b10;
  localparam logic [1:0] SYNC_Q = 2'b01;
  localparam int PAIRS_PER_WORD = 16;

  typedef enum logic {
    IDLE,
    SEND
  } tx_state_t;

endpackage

// File: rtl/at86rf215_iq_tx_iq_word_pack.sv
// Combinational packing of one I/Q sample pair into the chip's IQ word:
// {SYNC_I, I, i_ctrl, SYNC_Q, Q, q_ctrl}, most significant bit first on the wire.
module iq_word_pack #(
  parameter int         DATA_W = at86rf215_pkg::IQ_DATA_W,
  parameter logic [1:0] SYNC_I = at86rf215_pkg::SYNC_I,
  parameter logic [1:0] SYNC_Q = at86rf215_pkg::SYNC_Q
) (
  input  logic [DATA_W-1:0]       i_data,
  input  logic [DATA_W-1:0]       q_data,
  input  logic                    i_ctrl,
  input  logic                    q_ctrl,
  output logic [2*(DATA_W+3)-1:0] word
);

  assign word = {SYNC_I, i_data, i_ctrl, SYNC_Q, q_data, q_ctrl};

endmodule

// File: rtl/at86rf215_iq_tx.sv
// Transmit-side IQ serializer for the AT86RF215 LVDS baseband interface.
// A one-entry holding register feeds a 32-bit shift register that emits one
// 2-bit DDR pair per clock to an external ODDR; words are sent back to back
// as long as samples keep arriving.
module at86rf215_iq_tx #(
  parameter int         DATA_W        = at86rf215_pkg::IQ_DATA_W,
  parameter logic [1:0] SYNC_I        = at86rf215_pkg::SYNC_I,
  parameter logic [1:0] SYNC_Q        = at86rf215_pkg::SYNC_Q,
  parameter bit         UNDERRUN_MODE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_i,
  input  logic [DATA_W-1:0] s_q,
  input  logic              s_i_ctrl,
  input  logic              s_q_ctrl,
  output logic [1:0]        data_out,
  output logic              frame_start,
  output logic              active,
  output logic              underrun,
  output logic [15:0]       underrun_cnt
);

  import at86rf215_pkg::*;

  localparam int WORD_W = 2 * (DATA_W + 3);
  localparam int CNT_W  = $clog2(WORD_W / 2);
  localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(WORD_W / 2 - 1);

  tx_state_t         state;
  tx_state_t         state_next;

  logic              hold_full;
  logic [DATA_W-1:0] hold_i;
  logic [DATA_W-1:0] hold_q;
  logic              hold_i_ctrl;
  logic              hold_q_ctrl;

  logic [WORD_W-1:0] hold_word;
  logic [WORD_W-1:0] zero_word;
  logic [WORD_W-1:0] shreg;
  logic [CNT_W-1:0]  pair_cnt;

  logic              at_boundary;
  logic              load_now;
  logic              load_zero;
  logic              underrun_now;
  logic              accept;

  iq_word_pack #(
    .DATA_W (DATA_W),
    .SYNC_I (SYNC_I),
    .SYNC_Q (SYNC_Q)
  ) u_pack_hold (
    .i_data (hold_i),
    .q_data (hold_q),
    .i_ctrl (hold_i_ctrl),
    .q_ctrl (hold_q_ctrl),
    .word   (hold_word)
  );

  iq_word_pack #(
    .DATA_W (DATA_W),
    .SYNC_I (SYNC_I),
    .SYNC_Q (SYNC_Q)
  ) u_pack_zero (
    .i_data ('0),
    .q_data ('0),
    .i_ctrl (1'b0),
    .q_ctrl (1'b0),
    .word   (zero_word)
  );

  // The holding register may refill in the same edge that it hands its
  // contents to the shift register, which keeps a steady stream gapless.
  assign s_ready = en & ~rst & (~hold_full | load_now);
  assign accept  = s_valid & s_ready;

  // Next-state decision: start from IDLE when a sample waits, and at the last
  // pair of a word choose between the next sample, stopping, or an underrun.
  always_comb begin
    state_next   = state;
    at_boundary  = (pair_cnt == LAST_PAIR);
    load_now     = 1'b0;
    load_zero    = 1'b0;
    underrun_now = 1'b0;
    case (state)
      IDLE: begin
        if (en && hold_full) begin
          load_now   = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (at_boundary) begin
          if (en && hold_full) begin
            load_now = 1'b1;
          end else if (!en) begin
            state_next = IDLE;
          end else begin
            underrun_now = 1'b1;
            if (UNDERRUN_MODE) begin
              load_zero = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // One-entry holding register in front of the shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full <= 1'b0;
    end else if (accept) begin
      hold_i      <= s_i;
      hold_q      <= s_q;
      hold_i_ctrl <= s_i_ctrl;
      hold_q_ctrl <= s_q_ctrl;
      hold_full   <= 1'b1;
    end else if (load_now) begin
      hold_full <= 1'b0;
    end
  end

  // Shift register, pair counter and the registered DDR pair with its
  // frame_start/active qualifiers, all aligned to the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg       <= '0;
      pair_cnt    <= '0;
      data_out    <= 2'b00;
      frame_start <= 1'b0;
      active      <= 1'b0;
    end else begin
      if (state == SEND) begin
        data_out    <= shreg[WORD_W-1 -: 2];
        frame_start <= (pair_cnt == '0);
        active      <= 1'b1;
        shreg       <= shreg << 2;
        pair_cnt    <= pair_cnt + 1'b1;
      end else begin
        data_out    <= 2'b00;
        frame_start <= 1'b0;
        active      <= 1'b0;
      end
      if (load_now) begin
        shreg    <= hold_word;
        pair_cnt <= '0;
      end else if (load_zero) begin
        shreg    <= zero_word;
        pair_cnt <= '0;
      end
    end
  end

  // Underrun pulse and its saturating event counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun     <= 1'b0;
      underrun_cnt <= 16'd0;
    end else begin
      underrun <= underrun_now;
      if (underrun_now && (underrun_cnt != 16'hFFFF)) begin
        underrun_cnt <= underrun_cnt + 16'd1;
      end
    end
  end

endmodule
